// File: rtl/rdma_xmit_pkg.sv
// Shared RDMA link constants, state encoding and length/checksum helpers.
// Also used by the RDMA receiver when decoding the header.
package rdma_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
    localparam int          UDP_HDR_LEN     = 8;
    localparam int          RDMA_HDR_LEN    = 22;
    localparam int          IP_HDR_LEN      = 20;
    localparam int          HDR_BYTES       = 64;

    localparam logic [15:0] IP4_VER_IHL_TOS = 16'h4500;
    localparam logic [15:0] IP4_FLAGS_FRAG  = 16'h4000;
    localparam logic [15:0] IP4_TTL_PROT    = 16'h4011;

    typedef enum logic [2:0] {
        S_START,
        S_IDLE,
        S_HDR,
        S_DATA,
        S_RESP
    } state_t;

    // Each data beat is 64 bytes; a 256-beat burst gives exactly 16384.
    function automatic logic [15:0] udp_length(input logic [7:0] len);
        logic [15:0] beats;
        beats = {8'd0, len} + 16'd1;
        return (beats << 6) + 16'(UDP_HDR_LEN + RDMA_HDR_LEN);
    endfunction

    function automatic logic [15:0] ip4_length(input logic [7:0] len);
        return udp_length(len) + 16'(IP_HDR_LEN);
    endfunction

    function automatic logic [15:0] ip4_csum(input logic [15:0] ip4_len,
                                             input logic [31:0] src_ip,
                                             input logic [31:0] dst_ip);
        logic [31:0] sum;
        sum = 32'(IP4_VER_IHL_TOS) + 32'(ip4_len) + 32'(IP4_FLAGS_FRAG)
            + 32'(IP4_TTL_PROT) + 32'(src_ip[31:16]) + 32'(src_ip[15:0])
            + 32'(dst_ip[31:16]) + 32'(dst_ip[15:0]);
        sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        return ~sum[15:0];
    endfunction

endpackage

// File: rtl/rdma_xmit_if.sv
// AXI4 write channel (AW/W/B) plus the outgoing AXI-Stream, as seen by rdma_xmit.
interface rdma_xmit_if #(
    parameter int DATA_WBITS = 512,
    parameter int ADDR_WBITS = 64
);
    localparam int DATA_WBYTS = DATA_WBITS / 8;

    logic [ADDR_WBITS-1:0] S_AXI_AWADDR;
    logic [7:0]            S_AXI_AWLEN;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [DATA_WBITS-1:0] S_AXI_WDATA;
    logic [DATA_WBYTS-1:0] S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WLAST;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [DATA_WBITS-1:0] AXIS_RDMA_TDATA;
    logic [DATA_WBYTS-1:0] AXIS_RDMA_TKEEP;
    logic                  AXIS_RDMA_TVALID;
    logic                  AXIS_RDMA_TLAST;
    logic                  AXIS_RDMA_TREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        output AXIS_RDMA_TDATA, AXIS_RDMA_TKEEP, AXIS_RDMA_TVALID, AXIS_RDMA_TLAST,
        input  AXIS_RDMA_TREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        input  AXIS_RDMA_TDATA, AXIS_RDMA_TKEEP, AXIS_RDMA_TVALID, AXIS_RDMA_TLAST,
        output AXIS_RDMA_TREADY
    );
endinterface

// File: rtl/rdma_xmit_hdr_build.sv
// Combinational Ethernet/IPv4/UDP/RDMA header assembly, byte 0 = first DST_MAC byte.
// RDMA_XMIT_IPCSUM_EN adds the IPv4 checksum; otherwise that field is zero.
module rdma_hdr_build
    import rdma_pkg::*;
(
    input  logic [7:0]   len,
    input  logic [63:0]  addr,
    input  logic [47:0]  src_mac,
    input  logic [47:0]  dst_mac,
    input  logic [31:0]  src_ip,
    input  logic [31:0]  dst_ip,
    input  logic [15:0]  src_port,
    input  logic [15:0]  dst_port,
`ifdef RDMA_XMIT_IPCSUM_EN
    input  logic [15:0]  csum,
    output logic [15:0]  csum_next,
`endif
    output logic [511:0] hdr
);

    logic [15:0]  udp_len;
    logic [15:0]  ip4_len;
    logic [15:0]  csum_field;
    logic [511:0] hdr_be;

    assign udp_len = udp_length(len);
    assign ip4_len = ip4_length(len);

`ifdef RDMA_XMIT_IPCSUM_EN
    assign csum_next  = ip4_csum(ip4_len, src_ip, dst_ip);
    assign csum_field = csum;
`else
    assign csum_field = 16'h0000;
`endif

    assign hdr_be = {dst_mac, src_mac, ETH_TYPE_IPV4,
                     IP4_VER_IHL_TOS, ip4_len, 16'h0000, IP4_FLAGS_FRAG,
                     IP4_TTL_PROT, csum_field, src_ip, dst_ip,
                     src_port, dst_port, udp_len, 16'h0000,
                     addr, len, 104'd0};

    for (genvar i = 0; i < HDR_BYTES; i++) begin : g_swap
        assign hdr[8*i +: 8] = hdr_be[511-8*i -: 8];
    end

endmodule

// File: rtl/rdma_xmit.sv
// AXI4 write slave emitting one RDMA packet (header beat + W beats) per burst.
// Optional IPv4 checksum under RDMA_XMIT_IPCSUM_EN.
module rdma_xmit
    import rdma_pkg::*;
#(
    parameter int DATA_WBITS = 512,
    parameter int DATA_WBYTS = DATA_WBITS / 8,
    parameter int ADDR_WBITS = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [47:0] SRC_MAC,
    input  logic [47:0] DST_MAC,
    input  logic [31:0] SRC_IP,
    input  logic [31:0] DST_IP,
    input  logic [15:0] SRC_PORT,
    input  logic [15:0] DST_PORT,
    rdma_xmit_if.slave  bus,
    output logic        WLAST_ERR
);

    state_t       state, state_nxt;
    logic [63:0]  addr_reg;
    logic [7:0]   len_reg;
    logic [8:0]   beat;
    logic [511:0] hdr;
    logic [7:0]   hdr_len;
    logic         last_beat, aw_hs, w_hs;

    assign last_beat = (beat == {1'b0, len_reg});
    assign aw_hs     = (state == S_IDLE) && bus.S_AXI_AWVALID;
    assign w_hs      = (state == S_DATA) && bus.S_AXI_WVALID && bus.AXIS_RDMA_TREADY;

`ifdef RDMA_XMIT_IPCSUM_EN
    logic [15:0] csum_reg, csum_next;

    // In S_IDLE the builder sees the incoming AWLEN so the checksum can be
    // registered on AW acceptance and be ready on the first header cycle.
    assign hdr_len = (state == S_IDLE) ? bus.S_AXI_AWLEN : len_reg;

    always_ff @(posedge clk) begin
        if (!resetn)    csum_reg <= 16'h0000;
        else if (aw_hs) csum_reg <= csum_next;
    end
`else
    assign hdr_len = len_reg;
`endif

    rdma_hdr_build u_hdr (
        .len       (hdr_len),
        .addr      (addr_reg),
        .src_mac   (SRC_MAC),
        .dst_mac   (DST_MAC),
        .src_ip    (SRC_IP),
        .dst_ip    (DST_IP),
        .src_port  (SRC_PORT),
        .dst_port  (DST_PORT),
`ifdef RDMA_XMIT_IPCSUM_EN
        .csum      (csum_reg),
        .csum_next (csum_next),
`endif
        .hdr       (hdr)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_START;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_reg  <= '0;
            len_reg   <= '0;
            beat      <= '0;
            WLAST_ERR <= 1'b0;
        end else begin
            if (aw_hs) begin
                addr_reg <= 64'(bus.S_AXI_AWADDR);
                len_reg  <= bus.S_AXI_AWLEN;
                beat     <= '0;
            end
            if (w_hs) begin
                beat <= beat + 9'd1;
                if (bus.S_AXI_WLAST != last_beat) WLAST_ERR <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_START: state_nxt = S_IDLE;
            S_IDLE:  if (bus.S_AXI_AWVALID) state_nxt = S_HDR;
            S_HDR:   if (bus.AXIS_RDMA_TREADY) state_nxt = S_DATA;
            S_DATA:  if (w_hs && last_beat) state_nxt = S_RESP;
            S_RESP:  if (bus.S_AXI_BREADY) state_nxt = S_IDLE;
            default: state_nxt = S_START;
        endcase
    end

    always_comb begin
        bus.S_AXI_AWREADY    = 1'b0;
        bus.S_AXI_WREADY     = 1'b0;
        bus.S_AXI_BVALID     = 1'b0;
        bus.S_AXI_BRESP      = 2'b00;
        bus.AXIS_RDMA_TVALID = 1'b0;
        bus.AXIS_RDMA_TLAST  = 1'b0;
        bus.AXIS_RDMA_TKEEP  = '1;
        bus.AXIS_RDMA_TDATA  = DATA_WBITS'(hdr);
        case (state)
            S_IDLE: bus.S_AXI_AWREADY = 1'b1;
            S_HDR:  bus.AXIS_RDMA_TVALID = 1'b1;
            S_DATA: begin
                bus.AXIS_RDMA_TVALID = bus.S_AXI_WVALID;
                bus.S_AXI_WREADY     = bus.AXIS_RDMA_TREADY;
                bus.AXIS_RDMA_TDATA  = bus.S_AXI_WDATA;
                bus.AXIS_RDMA_TKEEP  = bus.S_AXI_WSTRB;
                bus.AXIS_RDMA_TLAST  = last_beat;
            end
            S_RESP: bus.S_AXI_BVALID = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rdma_xmit.sv
// Directed bench for rdma_xmit: table of bursts plus stall and mid-packet reset sequences.
module tb_rdma_xmit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [47:0] src_mac = 48'h02_11_22_33_44_55;
    logic [47:0] dst_mac = 48'h02_AA_BB_CC_DD_EE;
    logic [31:0] src_ip  = 32'h0A01_0101;
    logic [31:0] dst_ip  = 32'h0A01_0102;
    logic [15:0] src_port = 16'hC001;
    logic [15:0] dst_port = 16'h12B7;
    logic        wlast_err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rdma_xmit_if #(.DATA_WBITS(512), .ADDR_WBITS(64)) bus ();

    rdma_xmit #(.DATA_WBITS(512), .ADDR_WBITS(64)) dut (
        .clk(clk), .resetn(resetn),
        .SRC_MAC(src_mac), .DST_MAC(dst_mac), .SRC_IP(src_ip), .DST_IP(dst_ip),
        .SRC_PORT(src_port), .DST_PORT(dst_port),
        .bus(bus), .WLAST_ERR(wlast_err)
    );

    typedef struct {
        logic [7:0]  len;
        logic [63:0] addr;
        int          bad_beat;   // -1: WLAST only on the real last beat
        bit          stall;
        logic [15:0] udp;
        logic [15:0] ip4;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_csum(input logic [15:0] ip4);
        logic [15:0] w[10];
        logic [31:0] s;
        w = '{16'h4500, ip4, 16'h0000, 16'h4000, 16'h4011, 16'h0000,
              src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s += 32'(w[i]);
        while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    function automatic logic [15:0] exp_csum(input logic [15:0] ip4);
`ifdef RDMA_XMIT_IPCSUM_EN
        return ref_csum(ip4);
`else
        return 16'h0000;
`endif
    endfunction

    // Expected header as a byte stream, field by field in wire order.
    function automatic logic [511:0] exp_hdr(input vec_t v);
        logic [63:0] fv[19];
        int          fw[19];
        logic [511:0] r;
        int          p;
        fv = '{64'(dst_mac), 64'(src_mac), 64'h0800, 64'h4500, 64'(v.ip4), 64'h0,
               64'h4000, 64'h4011, 64'(exp_csum(v.ip4)), 64'(src_ip), 64'(dst_ip),
               64'(src_port), 64'(dst_port), 64'(v.udp), 64'h0, v.addr, 64'(v.len),
               64'h0, 64'h0};
        fw = '{6, 6, 2, 2, 2, 2, 2, 2, 2, 4, 4, 2, 2, 2, 2, 8, 1, 8, 5};
        r = '0;
        p = 0;
        for (int f = 0; f < 19; f++)
            for (int b = fw[f] - 1; b >= 0; b--) begin
                r[8*p +: 8] = fv[f][8*b +: 8];
                p++;
            end
        return r;
    endfunction

    task automatic run_burst(input vec_t v, input int abort_at);
        logic [511:0] eh, held;
        bit  hs, was_stalled;
        int  beat, cyc;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_AWADDR  = v.addr;
        bus.S_AXI_AWLEN   = v.len;
        @(negedge clk);
        chk("awready_idle", bus.S_AXI_AWREADY, 1);
        chk("tvalid_idle", bus.AXIS_RDMA_TVALID, 0);
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        eh = exp_hdr(v);
        for (cyc = 0; cyc < 100; cyc++) begin
            bus.AXIS_RDMA_TREADY = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("hdr_tvalid", bus.AXIS_RDMA_TVALID, 1);
            chk("hdr_tlast", bus.AXIS_RDMA_TLAST, 0);
            chk("hdr_tkeep", bus.AXIS_RDMA_TKEEP, {64{1'b1}});
            chk("hdr_tdata", bus.AXIS_RDMA_TDATA, eh);
            chk("hdr_wready", bus.S_AXI_WREADY, 0);
            if (cyc == 0) begin
                chk("hdr_ip4_len", {bus.AXIS_RDMA_TDATA[16*8 +: 8], bus.AXIS_RDMA_TDATA[17*8 +: 8]}, v.ip4);
                chk("hdr_udp_len", {bus.AXIS_RDMA_TDATA[38*8 +: 8], bus.AXIS_RDMA_TDATA[39*8 +: 8]}, v.udp);
                chk("hdr_burst_len", bus.AXIS_RDMA_TDATA[50*8 +: 8], v.len);
            end
            hs = bus.AXIS_RDMA_TREADY;
            @(posedge clk); #1;
            if (hs) break;
        end
        beat = 0;
        bus.S_AXI_WVALID = 1'b0;
        was_stalled = 1'b0;
        held = '0;
        for (cyc = 0; cyc < 5000 && beat <= int'(v.len); cyc++) begin
            if (abort_at >= 0 && beat == abort_at) return;
            if (!bus.S_AXI_WVALID) begin
                bus.S_AXI_WVALID = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.S_AXI_WDATA  = {16{$urandom}};
                bus.S_AXI_WSTRB  = {$urandom, $urandom};
                bus.S_AXI_WLAST  = (v.bad_beat >= 0) ? (beat == v.bad_beat) : (beat == int'(v.len));
            end
            bus.AXIS_RDMA_TREADY = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("data_tvalid", bus.AXIS_RDMA_TVALID, bus.S_AXI_WVALID);
            chk("data_wready", bus.S_AXI_WREADY, bus.AXIS_RDMA_TREADY);
            if (bus.S_AXI_WVALID) begin
                chk("data_tdata", bus.AXIS_RDMA_TDATA, bus.S_AXI_WDATA);
                chk("data_tkeep", bus.AXIS_RDMA_TKEEP, bus.S_AXI_WSTRB);
                chk("data_tlast", bus.AXIS_RDMA_TLAST, beat == int'(v.len));
                if (was_stalled) chk("stall_stable", bus.AXIS_RDMA_TDATA, held);
            end
            hs = bus.S_AXI_WVALID && bus.AXIS_RDMA_TREADY;
            was_stalled = bus.S_AXI_WVALID && !bus.AXIS_RDMA_TREADY;
            held = bus.AXIS_RDMA_TDATA;
            @(posedge clk); #1;
            if (hs) begin
                beat++;
                bus.S_AXI_WVALID = 1'b0;
            end
        end
        chk("beat_count", beat, int'(v.len) + 1);
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WLAST  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        @(negedge clk);
        chk("resp_bvalid", bus.S_AXI_BVALID, 1);
        chk("resp_bresp", bus.S_AXI_BRESP, 0);
        chk("resp_tvalid", bus.AXIS_RDMA_TVALID, 0);
        chk("resp_wready", bus.S_AXI_WREADY, 0);
        chk("resp_awready", bus.S_AXI_AWREADY, 0);
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        chk("resp_bvalid_hold", bus.S_AXI_BVALID, 1);
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        @(negedge clk);
        chk("post_bvalid", bus.S_AXI_BVALID, 0);
        chk("post_awready", bus.S_AXI_AWREADY, 1);
        chk("wlast_err", wlast_err, v.exp_err);
    endtask

    initial begin
        vecs[0] = '{8'd0,   64'h1234_5678_9ABC_DEF0, -1, 1'b0, 16'h005E, 16'h0072, 1'b0};
        vecs[1] = '{8'd255, 64'h0000_0000_0004_0000, -1, 1'b0, 16'h401E, 16'h4032, 1'b0};
        vecs[2] = '{8'd7,   64'h0000_00FF_0000_8000, -1, 1'b1, 16'h021E, 16'h0232, 1'b0};
        vecs[3] = '{8'd3,   64'h0000_0000_0000_0100,  1, 1'b0, 16'h011E, 16'h0132, 1'b1};
        vecs[4] = '{8'd1,   64'h0000_0000_0000_0200, -1, 1'b0, 16'h009E, 16'h00B2, 1'b1};

        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WLAST = 1'b0; bus.S_AXI_BREADY = 1'b0; bus.AXIS_RDMA_TREADY = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", bus.S_AXI_AWREADY, 0);
        chk("rst_wready", bus.S_AXI_WREADY, 0);
        chk("rst_bvalid", bus.S_AXI_BVALID, 0);
        chk("rst_bresp", bus.S_AXI_BRESP, 0);
        chk("rst_tvalid", bus.AXIS_RDMA_TVALID, 0);
        chk("rst_tlast", bus.AXIS_RDMA_TLAST, 0);
        chk("rst_wlast_err", wlast_err, 0);
        resetn = 1'b1;

        // Reference checksum for 10.1.1.1 -> 10.1.1.2 with ip4_length 0x0072.
        chk("ref_csum_const", ref_csum(16'h0072), 16'h2477);

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i], -1);
            if (i == 0) begin
                // Header of vector 0 is re-presented in S_IDLE only for TDATA; recheck via model.
                chk("csum_model", exp_csum(16'h0072),
`ifdef RDMA_XMIT_IPCSUM_EN
                    16'h2477
`else
                    16'h0000
`endif
                );
            end
        end

        // Mid-packet reset during a 16-beat burst.
        run_burst('{8'd15, 64'h0000_0000_0000_4000, -1, 1'b0, 16'h041E, 16'h0432, 1'b0}, 5);
        resetn = 1'b0;
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", bus.AXIS_RDMA_TVALID, 0);
        chk("midrst_wready", bus.S_AXI_WREADY, 0);
        chk("midrst_bvalid", bus.S_AXI_BVALID, 0);
        chk("midrst_awready", bus.S_AXI_AWREADY, 0);
        chk("midrst_wlast_err", wlast_err, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("start_awready", bus.S_AXI_AWREADY, 0);
        @(posedge clk);
        @(negedge clk);
        chk("idle_awready", bus.S_AXI_AWREADY, 1);
        run_burst(vecs[0], -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
